// File: rtl/ps2_key_decoder_if.sv
// Byte-stream handshake from the ps2_keyboard FIFO plus the decoded key status.
// The decoder connects through the slave view; the FIFO/consumer side uses master.
interface ps2_key_decoder_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       ps2_data;
  logic             ps2_ready;
  logic             nextdata_n;
  logic             key_valid;
  logic             key_ext;
  logic [7:0]       key_code;
  logic [7:0]       key_ascii;
  logic [CNT_W-1:0] press_cnt;
  logic             key_event;
  logic             event_break;

  modport slave (
    input  ps2_data, ps2_ready,
    output nextdata_n, key_valid, key_ext, key_code, key_ascii,
           press_cnt, key_event, event_break
  );

  modport master (
    output ps2_data, ps2_ready,
    input  nextdata_n, key_valid, key_ext, key_code, key_ascii,
           press_cnt, key_event, event_break
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Set-2 make/break/E0 decoder tracking the most recently made key; results land one clk after the last byte is sampled.
// Pops the ps2 FIFO at most once every 2 clks and only while ps2_ready=1; idles while the FIFO is empty.
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              resetn,
  ps2_key_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic             nd_q;
  logic             take;
  logic             byte_vld_q;
  logic [7:0]       byte_q;
  logic             do_make;
  logic             do_break;
  logic             ev_ext;
  logic             match;
  logic             key_valid_q;
  logic             key_ext_q;
  logic [7:0]       key_code_q;
  logic [7:0]       key_ascii_q;
  logic [CNT_W-1:0] press_cnt_q;
  logic             key_event_q;
  logic             event_break_q;

  function automatic logic [7:0] set2_ascii(input logic [7:0] sc);
    logic [7:0] a;
    a = 8'h00;
    case (sc)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  // Controller/ack bytes that carry no key information outside a prefix.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == 8'hE1) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hEE) || (b == 8'hFE);
  endfunction

  // The pop cycle (nd_q=0) blocks sampling, so the FIFO head has advanced before the next look.
  assign take = bus.ps2_ready & nd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nd_q       <= 1'b1;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      nd_q       <= ~take;
      byte_vld_q <= take;
      if (take) begin
        byte_q <= bus.ps2_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    do_make   = 1'b0;
    do_break  = 1'b0;
    ev_ext    = 1'b0;
    if (byte_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_q == 8'hE0) begin
            state_nxt = ST_EXT;
          end else if (byte_q == 8'hF0) begin
            state_nxt = ST_BRK;
          end else if (!is_ctrl_byte(byte_q)) begin
            do_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_q == 8'hF0) begin
            state_nxt = ST_EXTBRK;
          end else if (byte_q != 8'hE0) begin
            do_make   = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          do_break  = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_EXTBRK: begin
          do_break  = 1'b1;
          ev_ext    = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign match = key_valid_q && (key_ext_q == ev_ext) && (key_code_q == byte_q);

  // A make of the held key is typematic repeat; a break of any other key is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_valid_q   <= 1'b0;
      key_ext_q     <= 1'b0;
      key_code_q    <= 8'h00;
      key_ascii_q   <= 8'h00;
      press_cnt_q   <= '0;
      key_event_q   <= 1'b0;
      event_break_q <= 1'b0;
    end else begin
      key_event_q   <= 1'b0;
      event_break_q <= 1'b0;
      if (do_make && !match) begin
        key_valid_q <= 1'b1;
        key_ext_q   <= ev_ext;
        key_code_q  <= byte_q;
        key_ascii_q <= ev_ext ? 8'h00 : set2_ascii(byte_q);
        press_cnt_q <= press_cnt_q + 1'b1;
        key_event_q <= 1'b1;
      end else if (do_break && match) begin
        key_valid_q   <= 1'b0;
        key_event_q   <= 1'b1;
        event_break_q <= 1'b1;
      end
    end
  end

  assign bus.nextdata_n  = nd_q;
  assign bus.key_valid   = key_valid_q;
  assign bus.key_ext     = key_ext_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_ascii   = key_ascii_q;
  assign bus.press_cnt   = press_cnt_q;
  assign bus.key_event   = key_event_q;
  assign bus.event_break = event_break_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised and directed bench for ps2_key_decoder against a byte-level reference model fed from a modelled FIFO.
module tb_ps2_key_decoder;
  localparam int CNT_W = 2;

  localparam logic [7:0] LETTER_SC [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_SC [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] KEY_POOL [10] = '{
    8'h1C, 8'h32, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h75, 8'h6B, 8'h0D, 8'h66};
  localparam logic [7:0] CTRL_POOL [5] = '{8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE};

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  ps2_key_decoder_if #(.CNT_W(CNT_W)) bus ();

  ps2_key_decoder #(.CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int n_pops = 0;
  int ev_seen = 0;

  logic [7:0] fifo [$];

  // reference model: prefix flags plus the tracked-key status
  bit         m_ext, m_brk;
  bit         m_valid, m_kext, m_ev, m_evbrk;
  logic [7:0] m_code, m_ascii;
  int         m_cnt;
  bit         exp_nd, prev_exp_nd, prev_ready, prev_rstn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_model(input logic [7:0] c, input bit e);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++) if (LETTER_SC[i] == c) return 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (DIGIT_SC[i] == c) return 8'(8'h30 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_valid = 0; m_kext = 0; m_ev = 0; m_evbrk = 0;
    m_code = 8'h00; m_ascii = 8'h00; m_cnt = 0;
  endtask

  task automatic model_make(input logic [7:0] c, input bit e);
    if (m_valid && m_kext == e && m_code == c) return;
    m_code  = c;
    m_kext  = e;
    m_ascii = ascii_model(c, e);
    m_valid = 1;
    m_cnt   = (m_cnt + 1) % (1 << CNT_W);
    m_ev    = 1;
    m_evbrk = 0;
  endtask

  task automatic model_break(input logic [7:0] c, input bit e);
    if (m_valid && m_kext == e && m_code == c) begin
      m_valid = 0;
      m_ev    = 1;
      m_evbrk = 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit is_ctrl;
    is_ctrl = 0;
    for (int i = 0; i < 5; i++) if (CTRL_POOL[i] == b) is_ctrl = 1;
    if (m_brk) begin
      model_break(b, m_ext);
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (!(is_ctrl && !m_ext)) begin
      model_make(b, m_ext);
      m_ext = 0;
    end
  endtask

  // FIFO + checker: inputs change only at negedge, outputs compared at negedge
  initial begin
    logic [7:0] b;
    bus.ps2_ready = 1'b0;
    bus.ps2_data  = 8'h00;
    model_reset();
    prev_exp_nd = 1; prev_ready = 0; prev_rstn = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        model_reset();
        exp_nd = 1;
      end else begin
        exp_nd = !(prev_rstn && prev_exp_nd && prev_ready);
      end
      check("nextdata_n",  32'(bus.nextdata_n),  32'(exp_nd));
      check("key_valid",   32'(bus.key_valid),   32'(m_valid));
      check("key_ext",     32'(bus.key_ext),     32'(m_kext));
      check("key_code",    32'(bus.key_code),    32'(m_code));
      check("key_ascii",   32'(bus.key_ascii),   32'(m_ascii));
      check("press_cnt",   32'(bus.press_cnt),   32'(m_cnt));
      check("key_event",   32'(bus.key_event),   32'(m_ev));
      check("event_break", 32'(bus.event_break), 32'(m_evbrk));
      check("pop_when_empty", 32'(!bus.nextdata_n && fifo.size() == 0), 32'd0);
      if (bus.key_event) ev_seen++;
      m_ev = 0;
      m_evbrk = 0;
      prev_exp_nd = exp_nd;
      prev_rstn   = resetn;
      if (!bus.nextdata_n && fifo.size() > 0) begin
        b = fifo.pop_front();
        n_pops++;
        model_byte(b);
      end
      bus.ps2_ready = (fifo.size() > 0);
      bus.ps2_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      prev_ready    = bus.ps2_ready;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (fifo.size() != 0 && t < 300) begin
      step(1);
      t++;
    end
    if (fifo.size() != 0) check("drain_timeout", 32'(fifo.size()), 32'd0);
    step(3);
  endtask

  task automatic pulse_reset();
    step(1);
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    fifo.push_back(a);
    fifo.push_back(b);
  endtask

  initial begin
    int ev0, p0, r;
    logic [7:0] k;

    // reset held while a byte waits: no pop, outputs idle
    step(1);
    fifo.push_back(8'h1C);
    step(4);
    check("rst_nextdata_n", 32'(bus.nextdata_n), 32'd1);
    check("rst_pops", 32'(n_pops), 32'd0);
    resetn = 1'b1;
    drain();
    check("a_code", 32'(bus.key_code), 32'h1C);
    check("a_ascii", 32'(bus.key_ascii), 32'h61);
    check("a_valid", 32'(bus.key_valid), 32'd1);
    check("a_cnt", 32'(bus.press_cnt), 32'd1);
    send2(8'hF0, 8'h1C);
    drain();
    check("a_rel_valid", 32'(bus.key_valid), 32'd0);
    check("a_rel_code", 32'(bus.key_code), 32'h1C);
    check("a_events", 32'(ev_seen), 32'd2);

    // typematic repeat
    ev0 = ev_seen;
    fifo.push_back(8'h1C);
    send2(8'h1C, 8'h1C);
    send2(8'hF0, 8'h1C);
    drain();
    check("typ_events", 32'(ev_seen - ev0), 32'd2);
    check("typ_cnt", 32'(bus.press_cnt), 32'd2);

    // extended key, then a non-extended break that must be ignored
    send2(8'hE0, 8'h75);
    drain();
    check("ext_ext", 32'(bus.key_ext), 32'd1);
    check("ext_code", 32'(bus.key_code), 32'h75);
    check("ext_ascii", 32'(bus.key_ascii), 32'h00);
    fifo.push_back(8'hE0);
    send2(8'hF0, 8'h75);
    drain();
    check("ext_rel_valid", 32'(bus.key_valid), 32'd0);
    send2(8'hE0, 8'h75);
    send2(8'hF0, 8'h75);
    drain();
    check("ext_plainbrk_valid", 32'(bus.key_valid), 32'd1);

    // back-to-back bytes: one pop per 2 clks, none lost
    p0 = n_pops;
    send2(8'h16, 8'h1E);
    send2(8'h26, 8'h25);
    send2(8'h2E, 8'h36);
    drain();
    check("burst_pops", 32'(n_pops - p0), 32'd6);
    check("burst_code", 32'(bus.key_code), 32'h36);
    check("burst_ascii", 32'(bus.key_ascii), 32'h36);
    p0 = n_pops;
    step(6);
    check("idle_pops", 32'(n_pops - p0), 32'd0);

    // counter wrap after reset
    pulse_reset();
    fifo.push_back(8'h1C); drain(); check("wrap1", 32'(bus.press_cnt), 32'd1);
    fifo.push_back(8'h32); drain(); check("wrap2", 32'(bus.press_cnt), 32'd2);
    fifo.push_back(8'h21); drain(); check("wrap3", 32'(bus.press_cnt), 32'd3);
    fifo.push_back(8'h23); drain(); check("wrap0", 32'(bus.press_cnt), 32'd0);

    // reset discards a pending E0 prefix
    fifo.push_back(8'hE0);
    drain();
    pulse_reset();
    fifo.push_back(8'h75);
    drain();
    check("rstpfx_ext", 32'(bus.key_ext), 32'd0);
    check("rstpfx_code", 32'(bus.key_code), 32'h75);
    check("rstpfx_cnt", 32'(bus.press_cnt), 32'd1);

    // random sequences checked cycle by cycle by the model
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        k = KEY_POOL[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) fifo.push_back(8'hE0);
        fifo.push_back(k);
      end else if (r < 60) begin
        if (m_kext) fifo.push_back(8'hE0);
        send2(8'hF0, m_code);
      end else if (r < 70) begin
        if ($urandom_range(0, 1) == 1) fifo.push_back(8'hE0);
        send2(8'hF0, KEY_POOL[$urandom_range(0, 9)]);
      end else if (r < 78) begin
        if (m_kext) fifo.push_back(8'hE0);
        fifo.push_back(m_code);
      end else if (r < 86) begin
        fifo.push_back(CTRL_POOL[$urandom_range(0, 4)]);
      end else if (r < 97) begin
        fifo.push_back(8'($urandom_range(0, 255)));
      end else begin
        pulse_reset();
      end
      if ($urandom_range(0, 2) == 0) drain();
      else step($urandom_range(0, 3));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
